// File: rtl/ccu_ctrl_pkg.sv
// rtl/ccu_ctrl_pkg.sv - shared types, CR bit indices and snoop encodings for the CCU controller
package ccu_ctrl_pkg;

  localparam int IdWidth        = 4;
  localparam int AddrWidth      = 32;
  localparam int CacheLineBytes = 64;
  localparam int LineOffBits    = $clog2(CacheLineBytes);

  localparam int CrDataTransfer = 0;
  localparam int CrError        = 1;
  localparam int CrPassDirty    = 2;
  localparam int CrIsShared     = 3;
  localparam int CrWasUnique    = 4;

  localparam logic [3:0] ArReadOnce    = 4'b0000;
  localparam logic [3:0] ArReadShared  = 4'b0001;
  localparam logic [3:0] ArReadClean   = 4'b0010;
  localparam logic [3:0] ArReadUnique  = 4'b0111;
  localparam logic [3:0] ArCleanUnique = 4'b1011;
  localparam logic [3:0] ArMakeInvalid = 4'b1101;

  localparam logic [3:0] AcReadOnce     = 4'b0000;
  localparam logic [3:0] AcReadShared   = 4'b0001;
  localparam logic [3:0] AcReadUnique   = 4'b0111;
  localparam logic [3:0] AcCleanInvalid = 4'b1001;
  localparam logic [3:0] AcMakeInvalid  = 4'b1101;

  typedef enum logic {
    READ_SNP_DATA      = 1'b0,
    SEND_INVALID_ACK_R = 1'b1
  } su_op_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
  } ar_chan_t;

  typedef struct packed {
    ar_chan_t ar;
  } mst_req_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
  } snoop_ac_t;

  typedef logic [4:0] snoop_cr_t;

  function automatic logic [3:0] ac_snoop_of(input logic [3:0] ar_snoop);
    case (ar_snoop)
      ArReadShared, ArReadClean: return AcReadShared;
      ArReadUnique:              return AcReadUnique;
      ArCleanUnique:             return AcCleanInvalid;
      ArMakeInvalid:             return AcMakeInvalid;
      ArReadOnce:                return AcReadOnce;
      default:                   return AcReadShared;
    endcase
  endfunction

  // Invalidating snoops must be acknowledged by the snoop unit even when no cache supplied data.
  function automatic logic is_invalidating(input logic [3:0] ar_snoop);
    return (ar_snoop == ArCleanUnique) || (ar_snoop == ArMakeInvalid);
  endfunction

endpackage

// File: rtl/ccu_ctrl_snoop_collector.sv
// rtl/ccu_ctrl_snoop_collector.sv - per-port AC/CR tracking and folding of CR responses
module ccu_ctrl_snoop_collector
  import ccu_ctrl_pkg::*;
#(
  parameter int NoMstPorts = 4,
  parameter int MstIdxBits = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             active_i,
  input  logic      [NoMstPorts-1:0]       target_i,
  input  logic      [NoMstPorts-1:0]       ac_ready_i,
  input  snoop_cr_t [NoMstPorts-1:0]       cr_i,
  input  logic      [NoMstPorts-1:0]       cr_valid_i,
  output logic      [NoMstPorts-1:0]       ac_valid_o,
  output logic      [NoMstPorts-1:0]       cr_ready_o,
  output logic      [NoMstPorts-1:0]       done_next_o,
  output logic      [NoMstPorts-1:0]       avail_next_o,
  output logic      [NoMstPorts-1:0]       avail_o,
  output logic                             shared_o,
  output logic                             dirty_o,
  output logic      [MstIdxBits-1:0]       first_responder_o
);

  logic [NoMstPorts-1:0] sent_q, sent_d, done_q, done_d, avail_q, avail_d;
  logic                  shared_q, shared_d, dirty_q, dirty_d;
  logic                  unused_was_unique;

  assign ac_valid_o = active_i ? (target_i & ~sent_q) : '0;
  assign cr_ready_o = active_i ? (target_i & sent_q & ~done_q) : '0;

  always_comb begin
    sent_d   = sent_q;
    done_d   = done_q;
    avail_d  = avail_q;
    shared_d = shared_q;
    dirty_d  = dirty_q;
    if (clear_i) begin
      sent_d   = '0;
      done_d   = '0;
      avail_d  = '0;
      shared_d = 1'b0;
      dirty_d  = 1'b0;
    end else begin
      sent_d = sent_q | (ac_valid_o & ac_ready_i);
      for (int i = 0; i < NoMstPorts; i++) begin
        if (cr_ready_o[i] && cr_valid_i[i]) begin
          done_d[i] = 1'b1;
          if (cr_i[i][CrDataTransfer] && !cr_i[i][CrError]) avail_d[i] = 1'b1;
          shared_d = shared_d | cr_i[i][CrIsShared];
          dirty_d  = dirty_d | cr_i[i][CrPassDirty];
        end
      end
    end
  end

  always_comb begin
    first_responder_o = '0;
    for (int i = NoMstPorts - 1; i >= 0; i--) begin
      if (avail_q[i]) first_responder_o = MstIdxBits'(i);
    end
  end

  always_comb begin
    unused_was_unique = 1'b0;
    for (int i = 0; i < NoMstPorts; i++) unused_was_unique = unused_was_unique ^ cr_i[i][CrWasUnique];
  end

  assign done_next_o  = done_d;
  assign avail_next_o = avail_d;
  assign avail_o      = avail_q;
  assign shared_o     = shared_q;
  assign dirty_o      = dirty_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q   <= '0;
      done_q   <= '0;
      avail_q  <= '0;
      shared_q <= 1'b0;
      dirty_q  <= 1'b0;
    end else begin
      sent_q   <= sent_d;
      done_q   <= done_d;
      avail_q  <= avail_d;
      shared_q <= shared_d;
      dirty_q  <= dirty_d;
    end
  end

endmodule

// File: rtl/ccu_ctrl_snoop_dispatcher.sv
// rtl/ccu_ctrl_snoop_dispatcher.sv - sequences one coherent read: snoop broadcast, CR fold, dispatch or memory
module ccu_ctrl_snoop_dispatcher
  import ccu_ctrl_pkg::*;
#(
  parameter int  NoMstPorts    = 4,
  parameter type mst_req_t     = ccu_ctrl_pkg::mst_req_t,
  parameter type mst_ar_chan_t = ccu_ctrl_pkg::ar_chan_t,
  parameter type snoop_ac_t    = ccu_ctrl_pkg::snoop_ac_t,
  parameter type snoop_cr_t    = ccu_ctrl_pkg::snoop_cr_t,
  localparam int MstIdxBits    = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  mst_req_t                   req_i,
  input  logic [MstIdxBits-1:0]      req_initiator_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  output snoop_ac_t [NoMstPorts-1:0] ac_o,
  output logic [NoMstPorts-1:0]      ac_valid_o,
  input  logic [NoMstPorts-1:0]      ac_ready_i,
  input  snoop_cr_t [NoMstPorts-1:0] cr_i,
  input  logic [NoMstPorts-1:0]      cr_valid_i,
  output logic [NoMstPorts-1:0]      cr_ready_o,
  output logic                       su_valid_o,
  input  logic                       su_ready_i,
  output su_op_e                     su_op_o,
  output mst_req_t                   ccu_req_holder_o,
  output logic                       shared_o,
  output logic                       dirty_o,
  output logic [NoMstPorts-1:0]      data_available_o,
  output logic [MstIdxBits-1:0]      first_responder_o,
  output mst_ar_chan_t               mem_ar_o,
  output logic                       mem_ar_valid_o,
  input  logic                       mem_ar_ready_i
);

  typedef enum logic [1:0] {IDLE, SNOOP, DISPATCH, MEM} state_e;

  state_e                state_q, state_d;
  mst_req_t              req_q, req_d;
  logic [NoMstPorts-1:0] target_q, target_d;
  logic                  req_ready_q, req_ready_d;
  logic                  su_valid_q, su_valid_d;
  su_op_e                su_op_q, su_op_d;
  logic                  mem_ar_valid_q, mem_ar_valid_d;
  logic                  clear;
  logic [NoMstPorts-1:0] init_onehot, done_next, avail_next;
  snoop_ac_t             ac_payload;

  assign init_onehot = NoMstPorts'(1) << req_initiator_i;

  ccu_ctrl_snoop_collector #(
    .NoMstPorts (NoMstPorts),
    .MstIdxBits (MstIdxBits)
  ) u_collector (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .clear_i           (clear),
    .active_i          (state_q == SNOOP),
    .target_i          (target_q),
    .ac_ready_i        (ac_ready_i),
    .cr_i              (cr_i),
    .cr_valid_i        (cr_valid_i),
    .ac_valid_o        (ac_valid_o),
    .cr_ready_o        (cr_ready_o),
    .done_next_o       (done_next),
    .avail_next_o      (avail_next),
    .avail_o           (data_available_o),
    .shared_o          (shared_o),
    .dirty_o           (dirty_o),
    .first_responder_o (first_responder_o)
  );

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    target_d       = target_q;
    req_ready_d    = req_ready_q;
    su_valid_d     = su_valid_q;
    su_op_d        = su_op_q;
    mem_ar_valid_d = mem_ar_valid_q;
    clear          = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        req_d       = req_i;
        target_d    = ~init_onehot;
        clear       = 1'b1;
        req_ready_d = 1'b0;
        if (target_d == '0) begin
          state_d        = MEM;
          mem_ar_valid_d = 1'b1;
        end else begin
          state_d = SNOOP;
        end
      end
      // Decide on the mask update of this cycle so dispatch follows the last CR by one cycle.
      SNOOP: if (done_next == target_q) begin
        if ((avail_next != '0) || is_invalidating(req_q.ar.snoop)) begin
          state_d    = DISPATCH;
          su_valid_d = 1'b1;
          su_op_d    = (avail_next != '0) ? READ_SNP_DATA : SEND_INVALID_ACK_R;
        end else begin
          state_d        = MEM;
          mem_ar_valid_d = 1'b1;
        end
      end
      DISPATCH: if (su_ready_i) begin
        state_d     = IDLE;
        su_valid_d  = 1'b0;
        req_ready_d = 1'b1;
      end
      MEM: if (mem_ar_ready_i) begin
        state_d        = IDLE;
        mem_ar_valid_d = 1'b0;
        req_ready_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      req_q          <= '0;
      target_q       <= '0;
      req_ready_q    <= 1'b1;
      su_valid_q     <= 1'b0;
      su_op_q        <= READ_SNP_DATA;
      mem_ar_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      target_q       <= target_d;
      req_ready_q    <= req_ready_d;
      su_valid_q     <= su_valid_d;
      su_op_q        <= su_op_d;
      mem_ar_valid_q <= mem_ar_valid_d;
    end
  end

  always_comb begin
    ac_payload.addr  = {req_q.ar.addr[AddrWidth-1:LineOffBits], LineOffBits'(0)};
    ac_payload.snoop = ac_snoop_of(req_q.ar.snoop);
    ac_payload.prot  = req_q.ar.prot;
    for (int i = 0; i < NoMstPorts; i++) ac_o[i] = ac_payload;
  end

  assign req_ready_o      = req_ready_q;
  assign su_valid_o       = su_valid_q;
  assign su_op_o          = su_op_q;
  assign ccu_req_holder_o = req_q;
  assign mem_ar_o         = req_q.ar;
  assign mem_ar_valid_o   = mem_ar_valid_q;

endmodule

// File: tb/tb_ccu_ctrl_snoop_dispatcher.sv
// tb/tb_ccu_ctrl_snoop_dispatcher.sv - self-checking bench with directed and randomized coherent reads
module tb_ccu_ctrl_snoop_dispatcher;
  import ccu_ctrl_pkg::*;

  localparam int NP = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  mst_req_t            req;
  logic [1:0]          init;
  logic                req_valid, req_ready;
  snoop_ac_t [NP-1:0]  ac;
  logic [NP-1:0]       ac_valid, ac_ready;
  snoop_cr_t [NP-1:0]  cr;
  logic [NP-1:0]       cr_valid, cr_ready;
  logic                su_valid, su_ready;
  su_op_e              su_op;
  mst_req_t            holder;
  logic                shared, dirty;
  logic [NP-1:0]       avail;
  logic [1:0]          first;
  ar_chan_t            mem_ar;
  logic                mem_ar_valid, mem_ar_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ccu_ctrl_snoop_dispatcher dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_initiator_i(init),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .ac_o(ac), .ac_valid_o(ac_valid),
    .ac_ready_i(ac_ready), .cr_i(cr), .cr_valid_i(cr_valid), .cr_ready_o(cr_ready),
    .su_valid_o(su_valid), .su_ready_i(su_ready), .su_op_o(su_op), .ccu_req_holder_o(holder),
    .shared_o(shared), .dirty_o(dirty), .data_available_o(avail), .first_responder_o(first),
    .mem_ar_o(mem_ar), .mem_ar_valid_o(mem_ar_valid), .mem_ar_ready_i(mem_ar_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_ac_snoop(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010: return 4'b0001;
      4'b0111:          return 4'b0111;
      4'b1011:          return 4'b1001;
      4'b1101:          return 4'b1101;
      4'b0000:          return 4'b0000;
      default:          return 4'b0001;
    endcase
  endfunction

  // One full transaction; the expectations come from the read rules, not from DUT state.
  task automatic run_txn(input logic [1:0] ini, input logic [3:0] snp, input logic [31:0] addr,
                         input logic [3:0] id, input logic [NP-1:0][4:0] crv,
                         input logic [NP-1:0][3:0] ac_dly, input logic [NP-1:0][3:0] cr_dly,
                         input int hold, input string tag);
    logic [NP-1:0] tgt, e_avail, sent, crdone;
    logic          e_sh, e_dt, e_su;
    logic [1:0]    e_first;
    su_op_e        e_op;
    mst_req_t      e_req;
    int            sent_cyc[NP];
    int            ac_cnt[NP];
    int            c, last_cr;
    tgt = ~(4'b0001 << ini);
    e_avail = '0; e_sh = 1'b0; e_dt = 1'b0; e_first = 2'd0;
    for (int i = 0; i < NP; i++) begin
      if (tgt[i]) begin
        if (crv[i][0] && !crv[i][1]) e_avail[i] = 1'b1;
        e_sh = e_sh | crv[i][3];
        e_dt = e_dt | crv[i][2];
      end
    end
    for (int i = NP - 1; i >= 0; i--) if (e_avail[i]) e_first = 2'(i);
    e_su = (e_avail != 0) || (snp == 4'b1011) || (snp == 4'b1101);
    e_op = (e_avail != 0) ? READ_SNP_DATA : SEND_INVALID_ACK_R;
    e_req.ar = '{id: id, addr: addr, snoop: snp, prot: 3'(id)};
    sent = '0; crdone = '0; last_cr = -1;
    for (int i = 0; i < NP; i++) begin sent_cyc[i] = 0; ac_cnt[i] = 0; end

    @(negedge clk);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    req = e_req; init = ini; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    c = 0;
    forever begin
      if (c == 0) begin
        check({tag, "_ac_valid_first"}, ac_valid, tgt);
        check({tag, "_ac_payload"}, {ac[0], ac[3]},
              {2{addr[31:6], 6'b0, ref_ac_snoop(snp), 3'(id)}});
      end
      if (su_valid || mem_ar_valid) break;
      if (c > 300) begin
        check({tag, "_timeout"}, 1'b1, 1'b0);
        break;
      end
      for (int i = 0; i < NP; i++) begin
        ac_ready[i] = (c >= int'(ac_dly[i]));
        cr[i]       = crv[i];
        cr_valid[i] = sent[i] && !crdone[i] && (c >= sent_cyc[i] + 1 + int'(cr_dly[i]));
      end
      #1;
      for (int i = 0; i < NP; i++) begin
        if (cr_valid[i] && cr_ready[i]) begin crdone[i] = 1'b1; last_cr = c; end
        if (ac_valid[i] && ac_ready[i]) begin sent[i] = 1'b1; sent_cyc[i] = c; ac_cnt[i]++; end
      end
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    ac_ready = '0; cr_valid = '0;
    check({tag, "_latency"}, 64'(c), 64'(last_cr + 1));
    for (int i = 0; i < NP; i++) check({tag, "_ac_hs_count"}, 64'(ac_cnt[i]), {63'd0, tgt[i]});
    for (int h = 0; h <= hold; h++) begin
      if (e_su) begin
        check({tag, "_su_hold"}, {su_valid, mem_ar_valid, su_op, avail, shared, dirty},
              {1'b1, 1'b0, e_op, e_avail, e_sh, e_dt});
        if (e_avail != 0) check({tag, "_first"}, first, e_first);
        check({tag, "_holder"}, holder, e_req);
        su_ready = (h == hold);
      end else begin
        check({tag, "_mem_hold"}, {su_valid, mem_ar_valid, mem_ar}, {1'b0, 1'b1, e_req.ar});
        mem_ar_ready = (h == hold);
      end
      @(posedge clk);
      @(negedge clk);
    end
    su_ready = 1'b0; mem_ar_ready = 1'b0;
    check({tag, "_done"}, {su_valid, mem_ar_valid, req_ready}, 3'b001);
  endtask

  initial begin
    logic [NP-1:0][4:0] crv;
    logic [NP-1:0][3:0] ad, cd;
    logic [3:0]         snp_tab[6];
    snp_tab[0] = 4'b0001; snp_tab[1] = 4'b0010; snp_tab[2] = 4'b0111;
    snp_tab[3] = 4'b1011; snp_tab[4] = 4'b1101; snp_tab[5] = 4'b0000;
    rst_n = 1'b0; req = '0; init = '0; req_valid = 1'b0; ac_ready = '0; cr = '0;
    cr_valid = '0; su_ready = 1'b0; mem_ar_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {req_ready, su_valid, mem_ar_valid, ac_valid, cr_ready, avail, shared, dirty},
          {1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0});
    rst_n = 1'b1;

    // 1: ReadShared, no data anywhere -> memory
    run_txn(2'd0, 4'b0001, 32'h1234_5678, 4'h3, '0, '0, '0, 0, "t1");
    // 2: ports 2/3 shared data, port 1 clean miss
    crv = '0; crv[2] = 5'b01001; crv[3] = 5'b01001;
    run_txn(2'd0, 4'b0001, 32'h0000_0fc4, 4'h5, crv, '0, '0, 1, "t2");
    // 3: CleanUnique with no data -> invalidation ack
    run_txn(2'd0, 4'b1011, 32'hdead_beef, 4'h7, '0, '0, '0, 0, "t3");
    // 4: port 3 AC ready five cycles late, port 1 dirty data
    crv = '0; crv[1] = 5'b00101; ad = '0; ad[3] = 4'd5;
    run_txn(2'd0, 4'b0111, 32'h8000_0040, 4'h9, crv, ad, '0, 0, "t4");
    // 5: errored data on port 1 excluded, port 2 supplies data, snoop unit stalls 10 cycles
    crv = '0; crv[1] = 5'b00011; crv[2] = 5'b00001;
    run_txn(2'd0, 4'b0001, 32'h4000_1000, 4'h1, crv, '0, '0, 10, "t5");

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NP; i++) begin
        crv[i] = 5'($urandom);
        ad[i]  = 4'($urandom_range(0, 3));
        cd[i]  = 4'($urandom_range(0, 3));
      end
      run_txn(2'($urandom_range(0, 3)), snp_tab[$urandom_range(0, 5)], $urandom, 4'($urandom),
              crv, ad, cd, $urandom_range(0, 3), "rnd");
    end

    // 6: reset in the middle of the snoop phase
    @(negedge clk);
    req.ar = '{id: 4'h2, addr: 32'h0000_2000, snoop: 4'b0001, prot: 3'd0};
    init = 2'd1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; ac_ready = 4'b0001;
    @(negedge clk);
    ac_ready = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("t6_reset_mid_snoop", {req_ready, su_valid, mem_ar_valid, ac_valid, cr_ready, avail, shared, dirty},
          {1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle_after_reset", {req_ready, ac_valid}, {1'b1, 4'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
